mult_share_arbiter: RTL

- Shares one 8x8 signed Booth/Wallace multiplier between NUM_REQ requesters. The shared multiplier is the existing combinational booth_multiplier_top_module.
- Round-robin arbitration on the input side. Two-stage valid/ready pipeline: an operand register feeds the multiplier, and a result register follows it.
- Every response carries the requester ID. The block sits between multiple datapath clients (filters, MAC sequencers) and the single multiplier instance.

---
 rtl/mult_share_pkg.sv | 38 +++
 rtl/booth_multiplier_top_module.sv | 53 +++++
 rtl/mult_share_arbiter_rr_arbiter.sv | 49 ++++
 rtl/mult_share_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_pkg
// Purpose  : Shared widths, pipeline-entry types and pointer helper for the
//            shared-multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mult_share_pkg;

    localparam int OPND_W   = 8;
    localparam int PROD_W   = 16;
    // Widest requester ID the block supports (NUM_REQ up to 8).
    localparam int ID_MAX_W = 3;

    // Operand register contents.
    typedef struct packed {
        logic signed [OPND_W-1:0]   a;
        logic signed [OPND_W-1:0]   b;
        logic        [ID_MAX_W-1:0] id;
    } s1_entry_t;

    // Result register contents.
    typedef struct packed {
        logic signed [PROD_W-1:0]   product;
        logic        [ID_MAX_W-1:0] id;
    } s2_entry_t;

    // Round-robin pointer successor: (idx + 1) mod n.
    function automatic logic [ID_MAX_W-1:0] rr_next(input logic [ID_MAX_W-1:0] idx,
                                                    input int                  n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + ID_MAX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_multiplier_top_module.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_top_module
// Purpose  : Combinational signed 8x8 multiplier: radix-4 Booth partial
//            products reduced by a carry-save tree and one final adder.
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier_top_module (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    logic [15:0] a_ext;
    logic [8:0]  b_ext;
    logic [15:0] pp [4];
    logic [15:0] sum1, carry1, sum2, carry2;

    assign a_ext = {{8{a[7]}}, a};
    // Implicit zero below the LSB for the first Booth triplet.
    assign b_ext = {b, 1'b0};

    for (genvar j = 0; j < 4; j++) begin : g_pp
        logic [2:0]  sel;
        logic [15:0] mag;

        assign sel = b_ext[2*j+2 -: 3];

        // Booth digit selection in {-2,-1,0,+1,+2} times A.
        always_comb begin
            mag = '0;
            case (sel)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext << 1;
                3'b100:         mag = -(a_ext << 1);
                3'b101, 3'b110: mag = -a_ext;
                default:        mag = '0;
            endcase
        end

        assign pp[j] = mag << (2 * j);
    end

    // Two 3:2 compressor levels then a carry-propagate add; all modulo 2^16,
    // which is exact because every signed 8x8 product fits in 16 bits.
    assign sum1    = pp[0] ^ pp[1] ^ pp[2];
    assign carry1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign sum2    = sum1 ^ carry1 ^ pp[3];
    assign carry2  = ((sum1 & carry1) | (sum1 & pp[3]) | (carry1 & pp[3])) << 1;
    assign product = sum2 + carry2;

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant generator. Scans req from ptr upward with
//            wrap-around and returns the first hit as one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Position k steps after the pointer, wrapped modulo N.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p,
                                                  input int               k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] pos;

    // First requester at or after ptr wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        for (int k = 0; k < N; k++) begin
            pos = wrap_add(ptr, k);
            if (!grant_valid && req[pos]) begin
                grant_valid = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Shares one signed 8x8 multiplier between NUM_REQ requesters via
//            round-robin arbitration and a two-stage valid/ready pipeline
//            (operand register -> multiplier -> result register).
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_product,
    output logic                      busy
);

    s1_entry_t         s1_q;
    logic              s1_valid;
    s2_entry_t         s2_q;
    logic              s2_valid;
    logic [ID_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    logic               s2_free;
    logic               s1_adv;
    logic               s1_free;
    logic               accept;

    logic [OPND_W-1:0]  a_arr [NUM_REQ];
    logic [OPND_W-1:0]  b_arr [NUM_REQ];
    logic [PROD_W-1:0]  mult_p;
    logic               unused_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*OPND_W +: OPND_W];
        assign b_arr[i] = req_b[i*OPND_W +: OPND_W];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    booth_multiplier_top_module u_mult (
        .a       (s1_q.a),
        .b       (s1_q.b),
        .product (mult_p)
    );

    // Each stage may take a new entry when it is empty or is emptying now.
    assign s2_free   = !s2_valid || rsp_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign s1_free   = !s1_valid || s1_adv;
    assign req_ready = grant & {NUM_REQ{s1_free && !rst}};
    // The grant only names a requester that is valid, so this equals
    // |(req_valid & req_ready).
    assign accept    = grant_valid && s1_free && !rst;

    // Operand register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q.a   <= a_arr[grant_idx];
            s1_q.b   <= b_arr[grant_idx];
            s1_q.id  <= ID_MAX_W'(grant_idx);
            rr_ptr   <= ID_W'(rr_next(ID_MAX_W'(grant_idx), NUM_REQ));
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result register; holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s1_adv) begin
            s2_valid     <= 1'b1;
            s2_q.product <= mult_p;
            s2_q.id      <= s1_q.id;
        end else if (s2_valid && rsp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign rsp_valid   = s2_valid;
    assign rsp_id      = s2_q.id[ID_W-1:0];
    assign rsp_product = s2_q.product;
    assign busy        = s1_valid || s2_valid;

    // ID bits above ID_W stay zero for small NUM_REQ.
    assign unused_id   = ^s2_q.id;

endmodule
`default_nettype wire
